// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and types for the channel-select pipe
package mux_pkg;

   localparam int ZCNT_W = 16;

   typedef logic [1:0] occ_t;

   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_ONE   = 2'd1;
   localparam occ_t OCC_FULL  = 2'd2;

   function automatic occ_t next_occ(input occ_t occ, input logic push, input logic pop);
      return occ_t'(occ + occ_t'(push) - occ_t'(pop));
   endfunction

endpackage

// File: rtl/mux_skid_buf2.sv
// rtl/mux_skid_buf2.sv - 2-entry FIFO with registered in_ready and zeroed idle output
module mux_skid_buf2
   import mux_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready
);

   occ_t             occ;
   occ_t             occ_nxt;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic             ready_q;
   logic             push;
   logic             pop;

   assign push    = in_valid & ready_q;
   assign pop     = (occ != OCC_EMPTY) & dout_ready;
   assign occ_nxt = next_occ(occ, push, pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         occ     <= OCC_EMPTY;
         head    <= '0;
         tail    <= '0;
         ready_q <= 1'b1;
      end else begin
         occ     <= occ_nxt;
         // in_ready is a flop of the next occupancy, so dout_ready never reaches it combinationally
         ready_q <= (occ_nxt != OCC_FULL);
         case (occ)
            OCC_EMPTY: begin
               if (push) head <= in_data;
            end
            OCC_ONE: begin
               if (push && pop)  head <= in_data;
               else if (push)    tail <= in_data;
               else if (pop)     head <= '0;
            end
            default: begin
               if (pop) begin
                  head <= tail;
                  tail <= '0;
               end
            end
         endcase
      end
   end

   assign in_ready   = ready_q;
   assign dout       = head;
   assign dout_valid = (occ != OCC_EMPTY);

endmodule

// File: rtl/mux_n_busout_pipe.sv
// rtl/mux_n_busout_pipe.sv - gated N-way channel select into a 2-entry output buffer
// Optional zero-transfer counter enabled by defining MUX_ZERO_CNT_EN.
module mux_n_busout_pipe
   import mux_pkg::*;
#(
   parameter int WIDTH  = 2,
   parameter int NUM_IN = 2,
   localparam int SEL_W = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] din,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    en,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        dout,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic                    err,
   input  logic                    err_clr,
   output logic [ZCNT_W-1:0]       zcnt
);

   logic [WIDTH-1:0] chan;
   logic [WIDTH-1:0] data;
   logic             sel_ok;
   logic             force_zero;
   logic             push;

   always_comb begin
      chan = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) chan = din[k*WIDTH +: WIDTH];
      end
   end

   assign sel_ok     = ({1'b0, sel} < (SEL_W+1)'(NUM_IN));
   assign force_zero = ~en | ~sel_ok;
   assign data       = force_zero ? '0 : chan;
   assign push       = in_valid & in_ready;

   // A bad select is only an error when the gate is open; a new error beats a clear
   always_ff @(posedge clk) begin
      if (rst)                        err <= 1'b0;
      else if (push && en && !sel_ok) err <= 1'b1;
      else if (err_clr)               err <= 1'b0;
   end

`ifdef MUX_ZERO_CNT_EN
   logic [ZCNT_W-1:0] zcnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         zcnt_q <= '0;
      else if (push && force_zero && (zcnt_q != {ZCNT_W{1'b1}}))
         zcnt_q <= zcnt_q + 1'b1;
   end

   assign zcnt = zcnt_q;
`else
   assign zcnt = '0;
`endif

   mux_skid_buf2 #(.WIDTH(WIDTH)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .in_data    (data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

endmodule

// File: tb/tb_mux_n_busout_pipe.sv
// tb/tb_mux_n_busout_pipe.sv - randomized and directed checks against a queue reference model
module tb_mux_n_busout_pipe;

   localparam int W  = 4;
   localparam int N  = 3;
   localparam int SW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst;
   logic [N*W-1:0] din;
   logic [SW-1:0] sel;
   logic          en;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  dout;
   logic          dout_valid;
   logic          dout_ready;
   logic          err;
   logic          err_clr;
   logic [15:0]   zcnt;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic [W-1:0] q[$];
   logic         m_err  = 1'b0;
   int           m_zcnt = 0;

   mux_n_busout_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .sel        (sel),
      .en         (en),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .err        (err),
      .err_clr    (err_clr),
      .zcnt       (zcnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic iv, input logic [N*W-1:0] d, input logic [SW-1:0] s,
                      input logic e, input logic dr, input logic ec);
      logic         do_push;
      logic         do_pop;
      logic [W-1:0] val;
      int           si;
      rst = r; in_valid = iv; din = d; sel = s; en = e; dout_ready = dr; err_clr = ec;
      @(negedge clk);
      if (chk_en) begin
         chk("dout_valid", 16'(dout_valid), 16'(q.size() > 0));
         chk("dout", 16'(dout), (q.size() > 0) ? 16'(q[0]) : 16'h0);
         chk("in_ready", 16'(in_ready), 16'(q.size() < 2));
         chk("err", 16'(err), 16'(m_err));
`ifdef MUX_ZERO_CNT_EN
         chk("zcnt", zcnt, 16'(m_zcnt));
`else
         chk("zcnt", zcnt, 16'h0);
`endif
      end
      @(posedge clk);
      si  = int'(s);
      val = (e && si < N) ? W'(d >> (si * W)) : '0;
      if (r) begin
         q.delete();
         m_err  = 1'b0;
         m_zcnt = 0;
      end else begin
         do_pop  = (q.size() > 0) && dr;
         do_push = iv && (q.size() < 2);
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(val);
         if (do_push && e && si >= N) m_err = 1'b1;
         else if (ec)                 m_err = 1'b0;
         if (do_push && val == '0 && !(e && si < N) && m_zcnt < 65535) m_zcnt++;
      end
      #1;
   endtask

   initial begin
      cyc(1, 0, '0, 0, 0, 0, 0);
      chk_en = 1'b1;
      cyc(0, 0, '0, 0, 0, 0, 0);

      // channel select
      cyc(0, 1, 12'hCBA, 1, 1, 1, 0);
      chk("sel1_data", 16'(dout), 16'hB);
      cyc(0, 0, 12'hCBA, 1, 1, 1, 0);

      // gated push
      cyc(0, 1, 12'hCBA, 2, 0, 1, 0);
      chk("gated_data", 16'(dout), 16'h0);
      cyc(0, 0, 12'hCBA, 2, 0, 1, 0);

      // bad select, clear, clear racing a new error
      cyc(0, 1, 12'hCBA, 3, 1, 1, 0);
      chk("err_set", 16'(err), 16'h1);
      cyc(0, 0, 12'hCBA, 0, 1, 1, 1);
      chk("err_clr", 16'(err), 16'h0);
      cyc(0, 1, 12'hCBA, 3, 1, 1, 1);
      chk("err_set_wins", 16'(err), 16'h1);
      cyc(0, 0, '0, 0, 1, 1, 1);

      // back-pressure fill and drain
      cyc(0, 1, 12'h001, 0, 1, 0, 0);
      cyc(0, 1, 12'h002, 0, 1, 0, 0);
      chk("full_in_ready", 16'(in_ready), 16'h0);
      cyc(0, 1, 12'h003, 0, 1, 0, 0);
      chk("held_dout", 16'(dout), 16'h1);
      cyc(0, 0, '0, 0, 1, 1, 0);
      chk("drain_second", 16'(dout), 16'h2);
      cyc(0, 0, '0, 0, 1, 1, 0);
      cyc(0, 0, '0, 0, 1, 1, 0);

      // streaming at occupancy 1
      for (int i = 0; i < 8; i++) cyc(0, 1, 12'(i), 0, 1, 1, 0);
      cyc(0, 0, '0, 0, 1, 1, 0);
      cyc(0, 0, '0, 0, 1, 1, 0);

      // reset with a full buffer and a pending error
      cyc(0, 1, 12'h00E, 0, 1, 0, 0);
      cyc(0, 1, 12'hCBA, 3, 1, 0, 0);
      cyc(1, 1, 12'h00F, 0, 1, 1, 0);
      chk("rst_valid", 16'(dout_valid), 16'h0);
      chk("rst_ready", 16'(in_ready), 16'h1);

      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1), 12'($urandom),
             SW'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
             $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
      end
      cyc(0, 0, '0, 0, 0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_n_busout_pipe.md
MUX_N_BUSOUT_PIPE -- requirements
Module: mux_n_busout_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, meaning the data bits per channel (at least 1).
REQ-002 The block SHALL have parameter NUM_IN, default 2, meaning the number of input channels (at least 2).
REQ-003 The block SHALL have localparam SEL_W, equal to $clog2(NUM_IN), meaning the select width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all logic on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port din, input, NUM_IN*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port sel, input, SEL_W bits: channel select.
REQ-008 The block SHALL have port en, input, 1 bit: gate; 0 forces zero data.
REQ-009 The block SHALL have port in_valid, input, 1 bit: upstream offers a sample.
REQ-010 The block SHALL have port in_ready, output, 1 bit: block can accept.
REQ-011 The block SHALL have port dout, output, WIDTH bits: head-of-buffer data.
REQ-012 The block SHALL have port dout_valid, output, 1 bit: dout holds a valid sample.
REQ-013 The block SHALL have port dout_ready, input, 1 bit: downstream accepts.
REQ-014 The block SHALL have port err, output, 1 bit: sticky out-of-range-select flag.
REQ-015 The block SHALL have port err_clr, input, 1 bit: clears err.
REQ-016 The block SHALL have port zcnt, output, 16 bits: gated-zero transfer count (see Configuration).

Function
REQ-017 A push SHALL occur on a cycle where in_valid=1 and in_ready=1; a pop SHALL occur on a cycle where dout_valid=1 and dout_ready=1.
REQ-018 Pushed data SHALL be din channel sel when en=1 and sel<NUM_IN, and all-zero otherwise.
REQ-019 A push with en=1 and sel>=NUM_IN SHALL set err on the next edge; with en=0 the select is not checked.
REQ-020 err SHALL stay set until rst or err_clr; err_clr coinciding with a new error SHALL leave err=1 (set wins).
REQ-021 Data SHALL be held in a 2-entry FIFO; in_ready SHALL be 1 exactly when occupancy<2, a registered function of occupancy only (no combinational path from dout_ready).
REQ-022 Latency SHALL be 1 cycle: data pushed at edge N appears on dout with dout_valid=1 after edge N when the buffer was empty.
REQ-023 Simultaneous push and pop at occupancy 1 SHALL keep occupancy at 1 and present the new sample after the edge.
REQ-024 Pop at occupancy 2 SHALL move the second entry to the head with no bubble; no push is possible at occupancy 2.
REQ-025 dout SHALL hold its value and dout_valid SHALL stay 1 while dout_ready=0, and SHALL be all-zero whenever dout_valid=0.
REQ-026 Order SHALL be preserved, with no loss or duplication.

Reset
REQ-027 While rst=1 at a rising edge: occupancy=0, dout_valid=0, dout=0, in_ready=1 from the following cycle, err=0, zcnt=0.
REQ-028 Reset mid-operation SHALL discard buffered samples; a push or pop in the reset cycle SHALL be ignored.

Configuration
REQ-029 Macro MUX_ZERO_CNT_EN SHALL control the zero counter.
- Defined: zcnt increments on each push whose data was forced to zero (en=0 or bad select).
- Defined: zcnt saturates at 16'hFFFF.
- Defined: zcnt is cleared only by rst.
- Undefined: zcnt is tied to 0 and no counter flops exist.

Structure
REQ-030 A shared package mux_pkg SHALL hold the zero-count width constant (16) and the occupancy type (2-bit).
REQ-031 The 2-entry FIFO SHALL be a sub-module mux_skid_buf2, parameterised by WIDTH; selection and gating logic stay in the top level.

Verification
REQ-032 Scenario: WIDTH=4, NUM_IN=3, din={4'hC,4'hB,4'hA}, sel=1, en=1, push with dout_ready=1 -> dout=4'hB, dout_valid=1 one cycle later.
REQ-033 Scenario: en=0, sel=2, push -> dout=4'h0; zcnt=1 with MUX_ZERO_CNT_EN defined, 0 without.
REQ-034 Scenario: sel=3 (>=NUM_IN), en=1, push -> dout=0, err=1; err_clr pulse -> err=0; err_clr with a simultaneous bad push -> err=1.
REQ-035 Scenario: dout_ready=0, push 4'h1 then 4'h2 -> in_ready=0 after the second push, dout=4'h1 held; dout_ready=1 -> 4'h1 then 4'h2 on consecutive cycles, in_ready=1.
REQ-036 Scenario: streaming at occupancy 1 with in_valid=dout_ready=1 for 8 cycles and data 0..7 -> outputs 0..7 in order, no bubbles.
REQ-037 Scenario: rst asserted with 2 entries buffered -> next cycle dout_valid=0, dout=0, in_ready=1, err=0, zcnt=0.
